// File: rtl/bk_arith_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : bk_arith_pkg                                                 |
// | Description : Shared definitions for the Brent-Kung arithmetic blocks:     |
// |               slice width, serial-controller state encoding and a helper   |
// |               returning the number of slices for a given operand width.    |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package bk_arith_pkg;

  localparam int BK_SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bk_state_t;

  // Number of BK_SLICE_W-bit slices needed to cover a WIDTH-bit operand.
  function automatic int bk_num_slices(input int width);
    return width / BK_SLICE_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bk_slice4.sv
// +----------------------------------------------------------------------------+
// | Module      : bk_slice4                                                    |
// | Description : Combinational 4-bit Brent-Kung prefix adder slice.           |
// |               s = a + b + cin, with carry-out and the carry into bit 3     |
// |               (the latter lets the caller derive signed overflow).         |
// | Ports       : a[3:0], b[3:0], cin  -> operands and carry-in               |
// |               s[3:0]               <- sum                                 |
// |               cout                 <- carry out of bit 3                  |
// |               c3                   <- carry into bit 3                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module bk_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_g10;
  logic       w_p10;
  logic       w_g32;
  logic       w_p32;
  logic       w_g30;
  logic       w_p30;
  logic [3:0] w_c;

  // Bitwise generate / propagate.
  assign w_g = a & b;
  assign w_p = a ^ b;

  // Up-sweep: pairs, then the full 4-bit group.
  assign w_g10 = w_g[1] | (w_p[1] & w_g[0]);
  assign w_p10 = w_p[1] & w_p[0];
  assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
  assign w_p32 = w_p[3] & w_p[2];
  assign w_g30 = w_g32 | (w_p32 & w_g10);
  assign w_p30 = w_p32 & w_p10;

  // Down-sweep: carry into each bit, with cin acting as generate at bit -1.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g10  | (w_p10  & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_c[2]);

  assign s    = w_p ^ w_c;
  assign cout = w_g30 | (w_p30 & cin);
  assign c3   = w_c[3];

endmodule

`default_nettype wire

// File: rtl/bk_serial_subtractor.sv
// +----------------------------------------------------------------------------+
// | Module      : bk_serial_subtractor                                         |
// | Description : Digit-serial multi-precision subtractor, D = A - B - B_IN,   |
// |               one 4-bit Brent-Kung slice per clock (A + ~B + carry, with   |
// |               the carry register seeded by ~B_IN). Valid/ready handshake   |
// |               on both sides; back-to-back accept while retiring.          |
// | Ports       : CLK, RST (async, active-high)                                |
// |               IN_VALID/IN_READY, A, B, B_IN  -> operand channel           |
// |               OUT_VALID/OUT_READY, D, B_OUT  <- result channel            |
// |               OVF (only with BK_SUB_OVF_EN) <- signed overflow            |
// | Options     : `define BK_SUB_OVF_EN adds the OVF output.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module bk_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] D,
  output logic             B_OUT
`ifdef BK_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  import bk_arith_pkg::*;

  localparam int NS = bk_num_slices(WIDTH);
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NS - 1);

  if ((WIDTH < BK_SLICE_W) || ((WIDTH % BK_SLICE_W) != 0)) begin : g_width_check
    $error("bk_serial_subtractor: WIDTH must be a multiple of 4 and at least 4");
  end

  bk_state_t        r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic             r_bout;

  logic [CW+1:0]    w_shamt;
  logic [3:0]       w_a_sl;
  logic [3:0]       w_b_sl;
  logic [3:0]       w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_ins;

`ifdef BK_SUB_OVF_EN
  logic             r_ovf;
  logic             w_c3;
`else
  logic             w_c3_unused;
`endif

  // Bit offset of the active slice; slice k occupies bits [4k+3:4k].
  assign w_shamt = {r_cnt, 2'b00};
  assign w_a_sl  = 4'(r_a >> w_shamt);
  // Subtraction as A + ~B + carry: invert the subtrahend slice.
  assign w_b_sl  = ~4'(r_b >> w_shamt);
  assign w_mask  = WIDTH'(4'hF) << w_shamt;
  assign w_ins   = WIDTH'(w_sum) << w_shamt;

  bk_slice4 u_slice (
    .a    (w_a_sl),
    .b    (w_b_sl),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout),
`ifdef BK_SUB_OVF_EN
    .c3   (w_c3)
`else
    .c3   (w_c3_unused)
`endif
  );

  // Ready is held low while reset is asserted so nothing is accepted then.
  always_comb begin
    IN_READY = 1'b0;
    if (!RST) begin
      case (r_state)
        IDLE:    IN_READY = 1'b1;
        DONE:    IN_READY = OUT_READY;
        default: IN_READY = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_bout      <= 1'b0;
`ifdef BK_SUB_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_a     <= A;
            r_b     <= B;
            // Carry-in of the two's-complement add absorbs the borrow-in.
            r_carry <= ~B_IN;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end

        RUN: begin
          r_d     <= (r_d & ~w_mask) | w_ins;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            // No carry out of the top slice means the subtraction borrowed.
            r_bout      <= ~w_cout;
`ifdef BK_SUB_OVF_EN
            r_ovf       <= w_c3 ^ w_cout;
`endif
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end

        DONE: begin
          if (OUT_READY) begin
            r_out_valid <= 1'b0;
            if (IN_VALID) begin
              // Retire and accept in the same cycle.
              r_a     <= A;
              r_b     <= B;
              r_carry <= ~B_IN;
              r_cnt   <= '0;
              r_state <= RUN;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign OUT_VALID = r_out_valid;
  assign D         = r_d;
  assign B_OUT     = r_bout;
`ifdef BK_SUB_OVF_EN
  assign OVF       = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bk_serial_subtractor.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_bk_serial_subtractor                                      |
// | Description : Self-checking bench for bk_serial_subtractor (WIDTH = 16).   |
// |               Expected results are queued at operand acceptance and      |
// |               popped when OUT_VALID is observed.                          |
// | Options     : BK_SUB_OVF_EN also checks OVF.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bk_serial_subtractor;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
  } exp_t;

  logic             CLK;
  logic             RST;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             B_IN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] D;
  logic             B_OUT;
`ifdef BK_SUB_OVF_EN
  logic             OVF;
`endif

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  bk_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .B_IN      (B_IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .D         (D),
    .B_OUT     (B_OUT)
`ifdef BK_SUB_OVF_EN
    ,
    .OVF       (OVF)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: unsigned 17-bit difference for D/B_OUT, sign-extended for OVF.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] u;
    logic [16:0] s;
    exp_t        e;
    u      = {1'b0, a} - {1'b0, b} - {16'b0, bin};
    s      = {a[15], a} - {b[15], b} - {16'b0, bin};
    e.d    = u[15:0];
    e.bout = u[16];
    e.ovf  = s[16] ^ s[15];
    return e;
  endfunction

  // Present operands until accepted; push the expectation at the accept edge.
  // Returns with time 1 unit after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic to);
    A = a; B = b; B_IN = bin; IN_VALID = 1'b1; to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (IN_READY === 1'b1) begin
        @(posedge CLK);
        sb.push_back(model(a, b, bin));
        #1;
        to = 1'b0;
        break;
      end
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    // Scramble the operand bus; the block must ignore it after acceptance.
    A = 16'($urandom); B = 16'($urandom); B_IN = 1'($urandom);
  endtask

  task automatic wait_out(output int lat, output logic to);
    lat = 0;
    while ((OUT_VALID !== 1'b1) && (lat < 40)) begin
      @(posedge CLK); #1;
      lat++;
    end
    to = (OUT_VALID !== 1'b1);
  endtask

  task automatic test_reset;
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1; A = '0; B = '0; B_IN = 1'b0;
    #1;
    vectors++;
    if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
    vectors++;
    if (D !== 16'h0000) begin miscompares++; $display("FAIL reset_d: got %h want 0000", D); end
    vectors++;
    if (B_OUT !== 1'b0) begin miscompares++; $display("FAIL reset_bout: got %b want 0", B_OUT); end
`ifdef BK_SUB_OVF_EN
    vectors++;
    if (OVF !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", OVF); end
`endif
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if (IN_READY !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
  endtask

  task automatic test_basic;
    logic to;
    int   lat;
    exp_t e;
    OUT_READY = 1'b1;
    issue(16'h1234, 16'h0234, 1'b0, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL basic_accept: timeout got %b want 0", to); end
    wait_out(lat, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL basic_out_timeout: got %b want 0", to); end
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d want 4", lat); end
    e = sb.pop_front();
    vectors++;
    if (D !== e.d) begin miscompares++; $display("FAIL basic_d: got %h want %h", D, e.d); end
    vectors++;
    if (B_OUT !== e.bout) begin miscompares++; $display("FAIL basic_bout: got %b want %b", B_OUT, e.bout); end
    vectors++;
    if (IN_READY !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready_done: got %b want 1", IN_READY); end
    @(posedge CLK); #1;
    vectors++;
    if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL basic_retire: out_valid got %b want 0", OUT_VALID); end
  endtask

  task automatic test_boundaries;
    logic [15:0] ta [4] = '{16'h0000, 16'h8000, 16'h5A5A, 16'h0000};
    logic [15:0] tb [4] = '{16'h0001, 16'h7FFF, 16'h5A5A, 16'h0000};
    logic        tc [4] = '{1'b0,     1'b1,     1'b0,     1'b1};
    logic to;
    int   lat;
    exp_t e;
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i], tc[i], to);
      wait_out(lat, to);
      vectors++;
      if (to !== 1'b0) begin
        miscompares++; $display("FAIL boundary_%0d_timeout: got %b want 0", i, to);
        return;
      end
      e = sb.pop_front();
      vectors++;
      if ({B_OUT, D} !== {e.bout, e.d}) begin
        miscompares++;
        $display("FAIL boundary_%0d: got bout=%b d=%h want bout=%b d=%h", i, B_OUT, D, e.bout, e.d);
      end
`ifdef BK_SUB_OVF_EN
      vectors++;
      if (OVF !== e.ovf) begin miscompares++; $display("FAIL boundary_%0d_ovf: got %b want %b", i, OVF, e.ovf); end
`endif
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic        to;
    int          lat;
    exp_t        e;
    logic [15:0] d0;
    logic        b0;
    OUT_READY = 1'b0;
    issue(16'h9ABC, 16'h1357, 1'b1, to);
    wait_out(lat, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL stall_timeout: got %b want 0", to); return; end
    d0 = D; b0 = B_OUT;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      vectors++;
      if ({D, B_OUT, OUT_VALID, IN_READY} !== {d0, b0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got d=%h bout=%b ov=%b ir=%b want d=%h bout=%b ov=1 ir=0",
                 i, D, B_OUT, OUT_VALID, IN_READY, d0, b0);
      end
    end
    e = sb.pop_front();
    vectors++;
    if ({b0, d0} !== {e.bout, e.d}) begin
      miscompares++; $display("FAIL stall_result: got bout=%b d=%h want bout=%b d=%h", b0, d0, e.bout, e.d);
    end
    OUT_READY = 1'b1;
    issue(16'h0005, 16'h0003, 1'b0, to);
    vectors++;
    if ({to, OUT_VALID} !== 2'b00) begin
      miscompares++; $display("FAIL b2b_handshake: got to=%b ov=%b want to=0 ov=0", to, OUT_VALID);
    end
    wait_out(lat, to);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    e = sb.pop_front();
    vectors++;
    if ({B_OUT, D} !== {e.bout, e.d}) begin
      miscompares++; $display("FAIL b2b_result: got bout=%b d=%h want bout=%b d=%h", B_OUT, D, e.bout, e.d);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_abort;
    logic to;
    int   lat;
    exp_t e;
    OUT_READY = 1'b1;
    issue(16'hF00F, 16'h0FF0, 1'b0, to);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    vectors++;
    if ({OUT_VALID, D, B_OUT} !== {1'b0, 16'h0000, 1'b0}) begin
      miscompares++; $display("FAIL abort_async: got ov=%b d=%h bout=%b want ov=0 d=0000 bout=0", OUT_VALID, D, B_OUT);
    end
    sb.delete();
    @(posedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if ({IN_READY, OUT_VALID} !== 2'b10) begin
      miscompares++; $display("FAIL abort_idle: got ir=%b ov=%b want ir=1 ov=0", IN_READY, OUT_VALID);
    end
    issue(16'hFFFF, 16'hFFFF, 1'b0, to);
    wait_out(lat, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL abort_restart_timeout: got %b want 0", to); return; end
    e = sb.pop_front();
    vectors++;
    if ({B_OUT, D} !== {e.bout, e.d}) begin
      miscompares++; $display("FAIL abort_restart: got bout=%b d=%h want bout=%b d=%h", B_OUT, D, e.bout, e.d);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_random;
    logic        to;
    int          lat;
    exp_t        e;
    logic [15:0] a;
    logic [15:0] b;
    OUT_READY = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 15) == 0) ? a : 16'($urandom);
      issue(a, b, 1'($urandom_range(0, 1)), to);
      wait_out(lat, to);
      if (to !== 1'b0) begin
        vectors++; miscompares++;
        $display("FAIL random_%0d_timeout: got no OUT_VALID want OUT_VALID within 40 cycles", n);
        return;
      end
      OUT_READY = 1'($urandom_range(0, 1));
      if (!OUT_READY) begin
        repeat ($urandom_range(1, 2)) @(posedge CLK);
        #1;
      end
      e = sb.pop_front();
      vectors++;
      if ({B_OUT, D} !== {e.bout, e.d}) begin
        miscompares++;
        $display("FAIL random_%0d: a=%h b=%h got bout=%b d=%h want bout=%b d=%h", n, a, b, B_OUT, D, e.bout, e.d);
      end
`ifdef BK_SUB_OVF_EN
      vectors++;
      if (OVF !== e.ovf) begin miscompares++; $display("FAIL random_%0d_ovf: got %b want %b", n, OVF, e.ovf); end
`endif
      OUT_READY = 1'b1;
      // Half the time retire alone; otherwise the next issue retires back-to-back.
      if ($urandom_range(0, 1) == 0) begin
        @(posedge CLK); #1;
      end
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
